// File: rtl/mp_ifetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one-cycle-latency requests to
// mp_icache and queues {instruction, PC} pairs toward decode. Define IFETCH_BYPASS_EN for the empty-FIFO bypass.
module mp_ifetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  output logic        icache_ack,
  output logic [29:0] icache_addr,
  input  logic        icache_vld,
  input  logic [31:0] icache_data,
  input  logic        redirect_vld,
  input  logic [29:0] redirect_pc,
  output logic        dec_vld,
  input  logic        dec_rdy,
  output logic [31:0] dec_inst,
  output logic [29:0] dec_pc
);

  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(DEPTH);

  logic [29:0]    pc_q,       pc_d;
  logic [29:0]    req_pc_q,   req_pc_d;
  logic           inflight_q, inflight_d;
  logic           drop_q,     drop_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic [31:0] mem_inst_q [DEPTH];
  logic [29:0] mem_pc_q   [DEPTH];

  logic [PTR_W+1:0] occupancy;
  logic fifo_empty;
  logic resp_vld;
  logic byp_vld;
  logic push;
  logic pop;

  // Requests in flight reserve a FIFO slot so a response can never find the queue full.
  always_comb begin
    occupancy   = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, inflight_q};
    fifo_empty  = (count_q == '0);
    icache_ack  = icache_vld & ~redirect_vld & ~sys_rst & (occupancy < DEPTH_C);
    icache_addr = pc_q;
    resp_vld    = inflight_q & ~drop_q & ~redirect_vld & ~sys_rst;
`ifdef IFETCH_BYPASS_EN
    byp_vld     = resp_vld & fifo_empty;
`else
    byp_vld     = 1'b0;
`endif
  end

  always_comb begin
    dec_vld  = ~fifo_empty | byp_vld;
    dec_inst = '0;
    dec_pc   = '0;
    if (!fifo_empty) begin
      dec_inst = mem_inst_q[rd_ptr_q];
      dec_pc   = mem_pc_q[rd_ptr_q];
    end else if (byp_vld) begin
      dec_inst = icache_data;
      dec_pc   = req_pc_q;
    end
  end

  // A bypassed response consumed directly by decode never enters the queue.
  always_comb begin
    push = resp_vld & ~(byp_vld & dec_rdy);
    pop  = ~fifo_empty & dec_rdy;
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = icache_ack;
    drop_d     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_vld) begin
      pc_d     = redirect_pc;
      drop_d   = inflight_q;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (icache_ack) begin
        pc_d     = pc_q + 30'd1;
        req_pc_d = pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= icache_data;
      mem_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: doc/mp_ifetch.md
Name: mp_ifetch

Overview:
- Instruction-fetch front end that sits directly upstream of mp_icache.
- Owns the fetch PC and drives icache_ack/icache_addr toward the cache.
- Captures icache_data one cycle after each accepted request and queues instruction+PC pairs in a small FIFO toward decode (valid/ready).
- Supports a redirect (branch/exception) that flushes the queue and discards any in-flight response.

Parameters:
- RESET_PC, 30'h0000_0000, word address fetched first after reset.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- sysclk  in  1  clock; all state updates on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- icache_ack  out  1  fetch request; the cache latches icache_addr on this edge.
- icache_addr  out  30  word address of the request.
- icache_vld  in  1  cache ready to accept a request.
- icache_data  in  32  instruction for the previous accepted request.
- redirect_vld  in  1  redirect strobe.
- redirect_pc  in  30  new fetch word address.
- dec_vld  out  1  FIFO head valid.
- dec_rdy  in  1  decode accepts the head.
- dec_inst  out  32  head instruction.
- dec_pc  out  30  head word address.

Behaviour:
- Reset (sys_rst=1 at an edge):
  - pc<=RESET_PC; FIFO emptied (rd/wr pointers and count = 0); inflight<=0; drop<=0.
  - Outputs: icache_ack=0, dec_vld=0, dec_inst=0, dec_pc=0.
  - Reset asserted mid-operation discards the FIFO and any in-flight response; the first request after reset uses RESET_PC.
- Issue rule: icache_ack=1 when all of the following hold:
  - icache_vld=1
  - redirect_vld=0
  - count+inflight < DEPTH
  - Here count is the pre-edge occupancy; a same-cycle pop is not credited.
- Request and response timing:
  - icache_addr=pc, combinational.
  - On an edge with icache_ack=1: pc<=pc+1 (30-bit wrap, 3FFFFFFF->0), inflight<=1, req_pc<=pc.
  - Response: in the cycle after an accepted request, icache_data is valid.
  - If drop=0, {icache_data, req_pc} is written to the FIFO at the end of that cycle.
  - inflight clears unless a new request is accepted on the same edge.
- Throughput: back-to-back requests are allowed, one per cycle, when credits permit.
- Latency (no bypass): ack edge N -> data cycle N+1 -> dec_vld high in cycle N+2.
- FIFO:
  - Head is presented on dec_inst/dec_pc whenever dec_vld=1.
  - Pop on dec_vld&dec_rdy.
  - Simultaneous push and pop: count unchanged, pointers both advance mod DEPTH.
  - Push when full cannot occur (guaranteed by credits); the bench asserts this.
  - Pop when empty is ignored.
  - Outputs hold stable while dec_vld=1 and dec_rdy=0.
- Redirect (redirect_vld=1 at an edge), highest priority:
  - pc<=redirect_pc; FIFO flushed; no request issued this cycle.
  - drop<=inflight, so a response due next cycle is discarded; drop clears after that cycle.
  - A response arriving in the redirect cycle itself is discarded.
  - A pop in the redirect cycle still counts as consumed by decode; the FIFO is empty afterwards.
  - The first request after a redirect is issued the following cycle at redirect_pc.
- icache_vld low: no request issued; pc holds; queued entries still drain to decode.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a non-dropped response arrives, dec_vld=1 in the same cycle with dec_inst=icache_data and dec_pc=req_pc.
  - If dec_rdy=1 the entry is not written to the FIFO; otherwise it is written normally.
  - Latency becomes ack edge N -> dec_vld in cycle N+1.
- Undefined: responses always go through the FIFO (latency N+2); outputs come only from FIFO registers.

Test Plan:
- Reset then free-run with dec_rdy=1, icache_vld=1, memory word k = 32'h1000_0000+k -> dec_pc sequence 0,1,2,3... with matching dec_inst, one per cycle after a 2-cycle fill (1 cycle with IFETCH_BYPASS_EN).
- Backpressure: dec_rdy=0 from start -> exactly 4 entries (pc 0..3) queued, icache_ack low afterwards, no overflow. Raise dec_rdy -> pc 0..3 then 4 in order, no gap or duplicate.
- Redirect to 30'h100 with one request in flight and 2 entries queued -> FIFO emptied, in-flight word not delivered, next dec_pc=30'h100, then 30'h101.
- icache_vld held low for 3 cycles mid-stream -> icache_ack=0 and pc frozen during those cycles; the stream resumes at the next address with no skip.
- Wrap: redirect_pc=30'h3FFF_FFFF -> dec_pc 3FFFFFFF followed by 00000000.
- sys_rst asserted for 1 cycle mid-stream with the FIFO non-empty -> dec_vld=0 the next cycle, next delivered dec_pc=RESET_PC.
